// File: rtl/route_arbiter_rr.sv
// Round-robin sequencer that shares one downstream resource among 4 requesters.
// It runs one transaction at a time (IDLE -> ISSUE -> WAIT) and drives the request-mux and response-demux selects.
module route_arbiter_rr #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             req_valid,
    input  logic [4*WORD_SIZE-1:0] req_data,
    output logic [3:0]             req_ready,
    output logic [3:0]             resp_valid,
    output logic [WORD_SIZE-1:0]   resp_data,
    output logic [1:0]             mux_sel,
    output logic [1:0]             demux_sel,
    output logic                   res_valid,
    output logic [WORD_SIZE-1:0]   res_data,
    input  logic                   res_ready,
    input  logic                   res_resp_valid,
    input  logic [WORD_SIZE-1:0]   res_resp_data,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]           r_state;
    logic [1:0]           r_rr_ptr;
    logic [1:0]           r_grant;
    logic [WORD_SIZE-1:0] r_res_data;
    logic [CW-1:0]        r_count;
    logic                 r_timeout_err;

    logic [1:0] w_pick;
    logic [3:0] w_grant_onehot;
    logic       w_accept;
    logic       w_resp_fire;

    // Scan from r_rr_ptr upwards; descending loop lets the nearest requester win.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[r_rr_ptr + 2'(k)]) begin
                w_pick = r_rr_ptr + 2'(k);
            end
        end
    end

    // Handshake: the resource takes the request on a cycle where res_valid && res_ready;
    // res_valid/res_data stay unchanged until then. A response counts only while in WAIT.
    assign w_grant_onehot = 4'b0001 << r_grant;
    assign w_accept       = (r_state == ST_ISSUE) && res_ready && !reset;
    assign w_resp_fire    = (r_state == ST_WAIT) && res_resp_valid && !reset;

    assign req_ready   = w_accept ? w_grant_onehot : 4'b0000;
    assign resp_valid  = w_resp_fire ? w_grant_onehot : 4'b0000;
    assign resp_data   = w_resp_fire ? res_resp_data : '0;
    assign mux_sel     = r_grant;
    assign demux_sel   = r_grant;
    assign res_valid   = (r_state == ST_ISSUE);
    assign res_data    = r_res_data;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= 2'd0;
            r_grant       <= 2'd0;
            r_res_data    <= '0;
            r_count       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant    <= w_pick;
                        r_res_data <= req_data[w_pick*WORD_SIZE +: WORD_SIZE];
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (res_ready) begin
                        r_count <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the final allowed cycle still wins over the timeout.
                    if (res_resp_valid) begin
                        r_rr_ptr <= r_grant + 2'd1;
                        r_state  <= ST_IDLE;
                    end else if (r_count == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= r_grant + 2'd1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_route_arbiter_rr.sv
// Bench for route_arbiter_rr: table of directed transactions, hand-written timeout and reset
// sequences, then randomized transactions checked against a transaction-level round-robin model.
module tb_route_arbiter_rr;

    localparam int WS = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid;
    logic [4*WS-1:0] req_data;
    logic [3:0]    req_ready;
    logic [3:0]    resp_valid;
    logic [WS-1:0] resp_data;
    logic [1:0]    mux_sel;
    logic [1:0]    demux_sel;
    logic          res_valid;
    logic [WS-1:0] res_data;
    logic          res_ready;
    logic          res_resp_valid;
    logic [WS-1:0] res_resp_data;
    logic          busy;
    logic          timeout_err;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    route_arbiter_rr #(.WORD_SIZE(WS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mux_sel(mux_sel), .demux_sel(demux_sel),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .res_resp_valid(res_resp_valid), .res_resp_data(res_resp_data),
        .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: next round-robin start, sticky error, last grant.
    int m_ptr    = 0;
    bit m_terr   = 0;
    int m_last_g = 0;

    typedef struct {
        logic [3:0]    mask;
        logic [WS-1:0] base;
        int            rdy;
        int            resp;
        logic [WS-1:0] rword;
        int            exp_g;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [4*WS-1:0] make_words(input logic [WS-1:0] base);
        logic [4*WS-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*WS +: WS] = base ^ (16'(i) * 16'h1111) ^ 16'h2222;
        end
        return w;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"},  resp_data, 0);
        check({tag, "_mux_sel"},    mux_sel, 0);
        check({tag, "_demux_sel"},  demux_sel, 0);
        check({tag, "_res_valid"},  res_valid, 0);
        check({tag, "_res_data"},   res_data, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_timeout"},    timeout_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; req_data = '0; res_ready = 1'b0;
        res_resp_valid = 1'b0; res_resp_data = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        check_all_zero("rst_held");
        next_cycle();
        reset = 1'b0;
        m_ptr = 0; m_terr = 0; m_last_g = 0;
    endtask

    // One full transaction. Called at posedge+1 with the DUT in IDLE.
    // resp_dly >= TO means the resource never answers.
    task automatic do_txn(input logic [3:0] mask, input logic [4*WS-1:0] words,
                          input int rdy_dly, input int resp_dly,
                          input logic [WS-1:0] rword, input int exp_g, input bit noise);
        logic [WS-1:0] exp_word;
        exp_word = words[exp_g*WS +: WS];
        req_valid = mask; req_data = words; res_ready = 1'b0; res_resp_valid = noise;
        res_resp_data = 16'hDEAD;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_res_valid", res_valid, 0);
        check("idle_resp_valid", resp_valid, 0);
        check("idle_mux_hold", mux_sel, m_last_g);
        check("idle_timeout", timeout_err, m_terr);
        next_cycle();
        if (noise) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = {$urandom, $urandom};
        end
        for (int i = 0; i < rdy_dly; i++) begin
            res_ready = 1'b0;
            res_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("issue_res_valid", res_valid, 1);
            check("issue_res_data", res_data, exp_word);
            check("issue_req_ready", req_ready, 0);
            check("issue_mux_sel", mux_sel, exp_g);
            check("issue_resp_valid", resp_valid, 0);
            next_cycle();
        end
        res_ready = 1'b1;
        res_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check("accept_req_ready", req_ready, 4'b0001 << exp_g);
        check("accept_res_valid", res_valid, 1);
        check("accept_res_data", res_data, exp_word);
        check("accept_demux_sel", demux_sel, exp_g);
        check("accept_resp_valid", resp_valid, 0);
        next_cycle();
        res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        res_resp_valid = 1'b0;
        if (resp_dly < TO) begin
            for (int i = 0; i < resp_dly; i++) begin
                @(negedge clk);
                check("wait_resp_valid", resp_valid, 0);
                check("wait_busy", busy, 1);
                check("wait_res_valid", res_valid, 0);
                check("wait_req_ready", req_ready, 0);
                next_cycle();
            end
            res_resp_valid = 1'b1; res_resp_data = rword;
            @(negedge clk);
            check("resp_valid", resp_valid, 4'b0001 << exp_g);
            check("resp_data", resp_data, rword);
            check("resp_demux_sel", demux_sel, exp_g);
            next_cycle();
        end else begin
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                check("to_resp_valid", resp_valid, 0);
                check("to_busy", busy, 1);
                if (i == TO - 1) check("to_not_yet", timeout_err, m_terr);
                next_cycle();
            end
            m_terr = 1;
        end
        m_ptr = (exp_g + 1) % 4;
        m_last_g = exp_g;
        req_valid = '0; res_ready = 1'b0; res_resp_valid = 1'b0;
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{4'b0100, 16'hABCD, 0, 2, 16'h1234, 2};
        vecs[1]  = '{4'b1111, 16'h1000, 0, 0, 16'h0001, 3};
        vecs[2]  = '{4'b1111, 16'h2000, 0, 0, 16'h0002, 0};
        vecs[3]  = '{4'b1111, 16'h3000, 0, 0, 16'h0003, 1};
        vecs[4]  = '{4'b1111, 16'h4000, 0, 0, 16'h0004, 2};
        vecs[5]  = '{4'b1111, 16'h5000, 0, 0, 16'h0005, 3};
        vecs[6]  = '{4'b1111, 16'h6000, 0, 0, 16'h0006, 0};
        vecs[7]  = '{4'b0010, 16'h7000, 0, 1, 16'h0007, 1};
        vecs[8]  = '{4'b1001, 16'h8000, 0, 0, 16'h0008, 3};
        vecs[9]  = '{4'b1001, 16'h9000, 0, 0, 16'h0009, 0};
        vecs[10] = '{4'b0001, 16'hA5A5, 5, 0, 16'h000A, 0};
        vecs[11] = '{4'b1000, 16'hB00B, 0, TO - 1, 16'h000B, 3};
        vecs[12] = '{4'b0110, 16'hC0DE, 2, 3, 16'h000C, 1};

        do_reset();

        for (int v = 0; v < 13; v++) begin
            check("table_model_agrees", model_pick(vecs[v].mask), vecs[v].exp_g);
            do_txn(vecs[v].mask, make_words(vecs[v].base), vecs[v].rdy, vecs[v].resp,
                   vecs[v].rword, vecs[v].exp_g, 1'b0);
        end

        // Timeout with no response, then a normal transaction afterwards.
        do_txn(4'b0001, make_words(16'h7777), 0, TO, 16'h0, 0, 1'b0);
        do_txn(4'b1111, make_words(16'h8888), 0, 0, 16'h4321, 1, 1'b0);

        // Reset in WAIT with a response arriving during and after reset.
        req_valid = 4'b0100; req_data = make_words(16'h5555);
        next_cycle();
        req_valid = '0; res_ready = 1'b1;
        next_cycle();
        res_ready = 1'b0;
        reset = 1'b1; res_resp_valid = 1'b1; res_resp_data = 16'hBEEF;
        @(negedge clk);
        check("rst_wait_resp_valid", resp_valid, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("rst_wait");
        next_cycle();
        res_resp_valid = 1'b0;
        m_ptr = 0; m_terr = 0; m_last_g = 0;
        do_txn(4'b1111, make_words(16'h9999), 0, 0, 16'h5678, 0, 1'b0);

        // Randomized transactions with noise on unrelated inputs.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                res_resp_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("rand_idle_busy", busy, 0);
                check("rand_idle_resp", resp_valid, 0);
                next_cycle();
                res_resp_valid = 1'b0;
            end else begin
                logic [3:0] mask;
                int rd;
                int rs;
                mask = 4'($urandom_range(1, 15));
                rd = $urandom_range(0, 3);
                rs = ($urandom_range(0, 9) == 9) ? TO : $urandom_range(0, TO - 1);
                do_txn(mask, {$urandom, $urandom}, rd, rs, 16'($urandom),
                       model_pick(mask), 1'b1);
            end
        end

        @(negedge clk);
        check("final_busy", busy, 0);
        check("final_timeout", timeout_err, m_terr);
        check("final_mux_hold", mux_sel, m_last_g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
